// File: rtl/adc_sample_sequencer.sv
// Periodic SPI (mode 0) sampler for a single-channel ADC. A fixed command is sent
// each frame, the last WIDTH bits returned become a two's-complement sample strobe.
module adc_sample_sequencer #(
  parameter int                  WIDTH      = 10,
  parameter int                  SAMPLE_DIV = 200000,
  parameter int                  SCLK_HALF  = 5,
  parameter int                  FRAME_BITS = 16,
  parameter int                  CMD_BITS   = 5,
  parameter logic [CMD_BITS-1:0] CMD        = 5'b11000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_acq,
  input  logic                    clr_ovr,
  input  logic                    adc_miso,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic                    adc_mosi,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(SAMPLE_DIV + 1);
  localparam int HC_W  = $clog2(SCLK_HALF);
  localparam int HP_W  = $clog2(2 * FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [HC_W-1:0]           hc_q, hc_d;   // clk count within current sclk half-period
  logic [HP_W-1:0]           hp_q, hp_d;   // half-period index since cs_n fall
  logic [CMD_BITS-1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0]          shreg_q, shreg_d;
  logic signed [WIDTH-1:0]   sample_q, sample_d;
  logic                      cs_n_q, cs_n_d;
  logic                      sclk_q, sclk_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic                      tick, start, half_end, active_d, capture, publish, drop;

  always_comb begin
    tick     = en_acq && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    cnt_d    = (!en_acq || tick) ? '0 : cnt_q + 1'b1;
    half_end = (hc_q == HC_W'(SCLK_HALF - 1));
    state_d  = state_q;
    hc_d     = hc_q;
    hp_d     = hp_q;
    start    = 1'b0;

    case (state_q)
      IDLE: start = tick;
      SETUP, SHIFT: begin
        if (half_end) begin
          hc_d = '0;
          hp_d = hp_q + 1'b1;
          if (state_q == SETUP) begin
            state_d = SHIFT;
          end else if (hp_q == HP_W'(2 * FRAME_BITS - 1)) begin
            state_d = DONE;
            hp_d    = '0;
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      DONE: begin
        // a tick landing on the frame's last cycle is accepted back-to-back
        start   = tick;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SETUP;
      hc_d    = '0;
      hp_d    = '0;
    end

    drop     = tick && (state_q == SETUP || state_q == SHIFT);
    active_d = (state_d == SETUP) || (state_d == SHIFT);
    cs_n_d   = !active_d;
    sclk_d   = (state_d == SHIFT) && hp_d[0];

    if (start)                 cmd_d = CMD;
    else if (!active_d)        cmd_d = '0;
    else if (sclk_q && !sclk_d) cmd_d = cmd_q << 1;
    else                       cmd_d = cmd_q;

    // first clk of each sclk high phase; miso has been stable since the prior fall
    capture = (state_q == SHIFT) && sclk_q && (hc_q == '0);
    shreg_d = capture ? {shreg_q[WIDTH-2:0], adc_miso} : shreg_q;

    publish  = (state_q == SHIFT) && (state_d == DONE);
    sample_d = publish ? $signed({~shreg_q[WIDTH-1], shreg_q[WIDTH-2:0]}) : sample_q;
    valid_d  = publish;

    ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hc_q     <= '0;
      hp_q     <= '0;
      cmd_q    <= '0;
      shreg_q  <= '0;
      sample_q <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hc_q     <= hc_d;
      hp_q     <= hp_d;
      cmd_q    <= cmd_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_mosi     = cmd_q[CMD_BITS-1];
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed/random bench: behavioural ADC model with code table, frame monitor,
// overrun and back-to-back instances with shorter sample periods.
module tb_adc_sample_sequencer;

  logic clk = 1'b0;
  logic rst_n, en_acq, clr_ovr, adc_miso;
  logic adc_cs_n, adc_sclk, adc_mosi, sample_valid, overrun;
  logic signed [9:0] sample_out;

  logic en2, clr2, miso2;
  logic cs2, sclk2, mosi2, val2, ovr2;
  logic signed [9:0] smp2;

  logic en3, clr3, miso3;
  logic cs3, sclk3, mosi3, val3, ovr3;
  logic signed [9:0] smp3;

  always #5 clk = ~clk;

  adc_sample_sequencer #(.SAMPLE_DIV(100), .SCLK_HALF(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_acq(en_acq), .clr_ovr(clr_ovr), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi),
    .sample_out(sample_out), .sample_valid(sample_valid), .overrun(overrun));

  adc_sample_sequencer #(.SAMPLE_DIV(40), .SCLK_HALF(2)) u_ovr (
    .clk(clk), .rst_n(rst_n), .en_acq(en2), .clr_ovr(clr2), .adc_miso(miso2),
    .adc_cs_n(cs2), .adc_sclk(sclk2), .adc_mosi(mosi2),
    .sample_out(smp2), .sample_valid(val2), .overrun(ovr2));

  adc_sample_sequencer #(.SAMPLE_DIV(65), .SCLK_HALF(2)) u_b2b (
    .clk(clk), .rst_n(rst_n), .en_acq(en3), .clr_ovr(clr3), .adc_miso(miso3),
    .adc_cs_n(cs3), .adc_sclk(sclk3), .adc_mosi(mosi3),
    .sample_out(smp3), .sample_valid(val3), .overrun(ovr3));

  localparam int NTAB = 8;
  logic [9:0] code_tab [NTAB];

  int errs = 0;
  int nchk = 0;

  // ADC model + frame monitor, all evaluated away from the active edge
  int cyc = 0, nfall = 0, nload = 0, nfr = 0, nval = 0, vrun_err = 0;
  int j = 0, rises = 0, low = 0, fall_cyc = 0;
  logic [15:0] frame = '0, mosi_w = '0;
  logic [9:0]  cur_code = '0, code = '0;
  logic [31:0] junk;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
  int flen [64], frise [64], vcyc [64], vlat [64];
  logic [15:0] fmosi [64];
  logic signed [9:0] smp [64];
  logic [9:0] scode [64];

  initial adc_miso = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !adc_cs_n) begin
      nfall++;
      fall_cyc = cyc;
      code = (nload < NTAB) ? code_tab[nload] : 10'($urandom_range(0, 1023));
      nload++;
      junk = $urandom;
      frame = {junk[5:0], code};
      cur_code = code;
      j = 0; rises = 0; low = 0; mosi_w = '0;
    end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
      j++;
    end
    if (!adc_cs_n) begin
      low++;
      if (!prev_sclk && adc_sclk) begin
        rises++;
        mosi_w = {mosi_w[14:0], adc_mosi};
      end
    end
    if (!prev_cs && adc_cs_n && nfr < 64) begin
      flen[nfr] = low; frise[nfr] = rises; fmosi[nfr] = mosi_w;
      nfr++;
    end
    adc_miso = (j < 16) ? frame[15-j] : 1'b0;
    if (sample_valid) begin
      if (nval < 64) begin
        smp[nval] = sample_out; scode[nval] = cur_code;
        vcyc[nval] = cyc; vlat[nval] = cyc - fall_cyc;
      end
      nval++;
      if (prev_valid) vrun_err++;
    end
    prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_valid = sample_valid;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int k, h, bv, bf;
    rst_n = 1'b0; en_acq = 1'b0; clr_ovr = 1'b0;
    en2 = 1'b0; clr2 = 1'b0; miso2 = 1'b0;
    en3 = 1'b0; clr3 = 1'b0; miso3 = 1'b0;
    code_tab[0] = 10'h3FF; code_tab[1] = 10'h200; code_tab[2] = 10'h000; code_tab[3] = 10'h1FF;
    for (int i = 4; i < NTAB; i++) code_tab[i] = 10'($urandom_range(0, 1023));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 0);
    chk("rst_mosi", adc_mosi, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ovr2", ovr2, 0);

    // periodic acquisition with table codes (incl. 0x3FF, 0x200, 0x000, 0x1FF) and random codes
    rst_n = 1'b1;
    @(negedge clk);
    en_acq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (adc_cs_n && k < 300);
    chk("first_cs_fall_cycles", k, 100);
    k = 0;
    while (nval < NTAB && k < 1500) begin @(negedge clk); k++; end
    chk("frames_seen", nval >= NTAB, 1);
    for (int i = 0; i < NTAB; i++) begin
      chk($sformatf("sample[%0d]", i), smp[i], int'(scode[i]) - 512);
      chk($sformatf("cs_low_len[%0d]", i), flen[i], 64);
      chk($sformatf("sclk_pulses[%0d]", i), frise[i], 16);
      chk($sformatf("mosi_bits[%0d]", i), fmosi[i], 16'hC000);
      chk($sformatf("valid_latency[%0d]", i), vlat[i], 64);
      if (i > 0) chk($sformatf("period[%0d]", i), vcyc[i] - vcyc[i-1], 100);
    end
    repeat (20) @(negedge clk);
    chk("sample_hold", sample_out, int'(scode[nval-1]) - 512);

    // en_acq dropped mid-frame: frame completes, one strobe, then no more frames
    k = 0;
    while (adc_cs_n && k < 200) begin @(negedge clk); k++; end
    chk("drop_frame_started", adc_cs_n, 0);
    repeat (20) @(negedge clk);
    en_acq = 1'b0;
    bv = nval; bf = nfall;
    repeat (300) @(negedge clk);
    chk("drop_one_valid", nval - bv, 1);
    chk("drop_no_new_frame", nfall - bf, 0);
    chk("drop_cs_idle", adc_cs_n, 1);
    chk("drop_sample", sample_out, int'(scode[nval-1]) - 512);

    // overrun: 40-cycle period, 65-cycle frame occupancy
    en2 = 1'b1;
    k = 0;
    while (cs2 && k < 200) begin @(negedge clk); k++; end
    chk("ovr_first_tick_ok", ovr2, 0);
    repeat (40) @(negedge clk);
    chk("ovr_set_second_tick", ovr2, 1);
    repeat (10) @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("ovr_cleared", ovr2, 0);
    repeat (67) @(negedge clk);
    chk("ovr_still_clear", ovr2, 0);
    clr2 = 1'b1;
    @(negedge clk);
    chk("ovr_clr_before_drop", ovr2, 0);
    @(negedge clk);
    clr2 = 1'b0;
    chk("ovr_set_beats_clr", ovr2, 1);
    @(negedge clk);
    chk("ovr_sticky", ovr2, 1);
    en2 = 1'b0;

    // back-to-back: tick lands on the DONE cycle
    en3 = 1'b1;
    k = 0;
    while (cs3 && k < 200) begin @(negedge clk); k++; end
    k = 0;
    while (!cs3 && k < 200) begin @(negedge clk); k++; end
    chk("b2b_cs_low", k, 64);
    h = 0;
    while (cs3 && h < 200) begin @(negedge clk); h++; end
    chk("b2b_cs_high_gap", h, 1);
    repeat (200) @(negedge clk);
    chk("b2b_no_overrun", ovr3, 0);
    en3 = 1'b0;

    // asynchronous reset mid-frame
    en_acq = 1'b1;
    k = 0;
    while (adc_cs_n && k < 200) begin @(negedge clk); k++; end
    repeat (30) @(negedge clk);
    bv = nval;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", adc_cs_n, 1);
    chk("arst_sclk", adc_sclk, 0);
    chk("arst_mosi", adc_mosi, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_sample", sample_out, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (adc_cs_n && k < 300);
    chk("arst_restart_cycles", k, 100);
    chk("arst_no_valid", nval - bv, 0);
    chk("valid_one_cycle", vrun_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/adc_sample_sequencer.md
ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, sample width in bits for both the ADC code and sample_out.
REQ-002 SHALL have parameter SAMPLE_DIV, default 200000, clk cycles per sample period (50 Hz at 10 MHz).
REQ-003 SHALL have parameter SCLK_HALF, default 5, clk cycles per sclk half-period; legal range >=2.
REQ-004 SHALL have parameter FRAME_BITS, default 16, sclk cycles per conversion frame; constraint FRAME_BITS >= CMD_BITS + WIDTH.
REQ-005 SHALL have parameter CMD_BITS, default 5, command length in bits.
REQ-006 SHALL have parameter CMD, default 5'b11000, command word (start, single-ended, channel 0), sent MSB first.
REQ-007 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port en_acq, input, 1 bit: acquisition enable.
REQ-010 SHALL have port clr_ovr, input, 1 bit: synchronous clear of overrun.
REQ-011 SHALL have port adc_miso, input, 1 bit: serial data from the ADC.
REQ-012 SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-013 SHALL have port adc_sclk, output, 1 bit: serial clock, idle low (SPI mode 0).
REQ-014 SHALL have port adc_mosi, output, 1 bit: serial command to the ADC.
REQ-015 SHALL have port sample_out, output, signed WIDTH bits: two's-complement sample, which directly drives the LPF x_in.
REQ-016 SHALL have port sample_valid, output, 1 bit: one-cycle strobe, which directly drives the LPF en.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag indicating a sample tick was dropped.

Function
REQ-018 SHALL implement the tick counter as follows:
- counts 0..SAMPLE_DIV-1 while en_acq=1 and wraps;
- held at 0 while en_acq=0;
- tick = en_acq && count==SAMPLE_DIV-1.
REQ-019 SHALL implement the FSM states IDLE, SETUP, SHIFT and DONE with these transitions:
- IDLE->SETUP on tick;
- SETUP->SHIFT after SCLK_HALF cycles;
- SHIFT->DONE after the FRAME_BITS-th falling sclk edge;
- DONE->IDLE after 1 cycle.
REQ-020 SHALL drive adc_cs_n low on the first SETUP cycle and high again on entering DONE; adc_cs_n is high in IDLE and DONE.
REQ-021 SHALL place sclk edges relative to the adc_cs_n fall as follows:
- rising edge k (k=0..FRAME_BITS-1) at cycle SCLK_HALF*(2k+1);
- falling edge k at cycle SCLK_HALF*(2k+2);
- sclk is low outside SHIFT.
REQ-022 SHALL drive adc_mosi as follows:
- bit CMD[CMD_BITS-1] is valid from the adc_cs_n fall;
- the next bit is presented on each sclk falling edge;
- after CMD_BITS bits, and in IDLE, adc_mosi is 0.
REQ-023 SHALL sample adc_miso on the clk cycle of each sclk rising edge into a FRAME_BITS shift register, MSB first.
REQ-024 SHALL take the raw code as the last WIDTH bits captured in the frame and discard the earlier bits.
REQ-025 SHALL form sample_out = raw with its MSB inverted (offset-binary to two's complement): 0x200 -> 0, 0x3FF -> +511, 0x000 -> -512.
REQ-026 SHALL update sample_out and pulse sample_valid for exactly one cycle in DONE, i.e. 2*FRAME_BITS*SCLK_HALF cycles after the adc_cs_n fall.
REQ-027 SHALL hold sample_out between strobes.
REQ-028 SHALL handle a tick outside IDLE as follows: the tick is dropped and overrun is set to 1; overrun stays 1 until clr_ovr=1.
REQ-029 SHALL give set priority when a tick drop and clr_ovr=1 occur in the same cycle (overrun stays 1).
REQ-030 SHALL complete an in-flight frame normally and publish it when en_acq falls mid-frame, then start no further frames.
REQ-031 SHALL be able to issue a tick on the cycle DONE->IDLE occurs; that tick is not an overrun and a new frame starts the next cycle.

Reset
REQ-032 SHALL, while rst_n=0, force:
- FSM to IDLE and the tick counter to 0;
- adc_cs_n=1, adc_sclk=0, adc_mosi=0;
- sample_out=0, sample_valid=0, overrun=0.
REQ-033 SHALL, on reset mid-frame, abort the frame immediately with no sample_valid, then restart the count from 0 after rst_n rises.

Verification
REQ-034 SHALL pass this scenario (SAMPLE_DIV=100, SCLK_HALF=2): en_acq=1, ADC model returns 0x3FF -> adc_cs_n low for 64 cycles, 16 sclk pulses, sample_out=+511, sample_valid 1 cycle; repeats every 100 cycles.
REQ-035 SHALL pass this scenario: ADC codes 0x200 then 0x000 then 0x1FF -> sample_out 0, -512, -1.
REQ-036 SHALL pass this scenario: ADC model checks mosi -> first 5 bits received on rising sclk = 1,1,0,0,0, then zeros.
REQ-037 SHALL pass this scenario: SAMPLE_DIV=40 (< frame length 64) -> overrun=1 after second tick; clr_ovr pulse -> overrun=0 unless a drop occurs in the same cycle.
REQ-038 SHALL pass this scenario: en_acq deasserted at cycle 20 of a frame -> frame completes, one sample_valid, then adc_cs_n stays high.
REQ-039 SHALL pass this scenario: rst_n pulsed low at cycle 30 of a frame -> adc_cs_n=1, adc_sclk=0 asynchronously, no sample_valid, sample_out=0.
